// File: rtl/dm_pkg.sv
// dm_pkg: shared size/exception encodings, FSM state type and load extraction for dm_bytelane.
`ifndef TRAP_STALL
`define TRAP_STALL 8'hFF
`endif
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [7:0] EXC_ADEL = 8'h04;
  localparam logic [7:0] EXC_ADES = 8'h05;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic logic [31:0] dm_extract(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz, input logic sx);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return sz == SZ_BYTE ? {{24{sx & s[7]}}, s[7:0]} : sz == SZ_HALF ? {{16{sx & s[15]}}, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/dm_bytelane_if.sv
// dm_bytelane_if: MEM-stage data memory bus between pipeline and dm_bytelane.
interface dm_bytelane_if #(parameter int ADDR_WIDTH = 12);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] din, dout;
  logic we, re, sign_ext, busy;
  logic [1:0] size;
  logic [7:0] exception_in, exception;
  modport master(output addr, din, we, re, size, sign_ext, exception_in, input dout, exception, busy);
  modport slave(input addr, din, we, re, size, sign_ext, exception_in, output dout, exception, busy);
endinterface

// File: rtl/dm_byte_ram.sv
// dm_byte_ram: single-port read-first 32-bit RAM with per-byte write enables.
module dm_byte_ram #(parameter int AW = 10) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic          i_re,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: byte/half/word data memory with zero-fill INIT and registered exceptions.
// Define DM_ALIGN_CHECK_EN to raise EXC_ADEL/EXC_ADES on misaligned accesses instead of truncating.
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_CLEAR = 1'b1
) (
  input logic clk,
  input logic rst_n,
  dm_bytelane_if.slave bus
);
  localparam int WA = ADDR_WIDTH - 2;
  state_t r_state, w_state;
  logic [WA-1:0] r_clr_idx, w_clr_idx, w_waddr;
  logic [7:0] r_exc, w_exc;
  logic [1:0] r_size, r_off, w_off;
  logic r_sext, w_mis, w_re;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_rdata;
  // Lane offset already truncated, so misaligned accesses without the check still hit a legal lane.
  assign w_off = bus.size == SZ_BYTE ? bus.addr[1:0] : bus.size == SZ_HALF ? {bus.addr[1], 1'b0} : 2'b00;
`ifdef DM_ALIGN_CHECK_EN
  assign w_mis = bus.size == SZ_HALF ? bus.addr[0] : bus.size != SZ_BYTE && bus.addr[1:0] != 2'b00;
`else
  assign w_mis = 1'b0;
`endif
  always_comb begin
    w_state = r_state;
    w_clr_idx = r_clr_idx;
    w_exc = r_exc;
    w_be = 4'h0;
    w_re = 1'b0;
    w_waddr = bus.addr[ADDR_WIDTH-1:2];
    w_wdata = bus.size == SZ_BYTE ? {4{bus.din[7:0]}} : bus.size == SZ_HALF ? {2{bus.din[15:0]}} : bus.din;
    if (r_state == ST_INIT) begin
      w_be = 4'hF;
      w_waddr = r_clr_idx;
      w_wdata = '0;
      w_clr_idx = r_clr_idx + 1'b1;
      w_state = &r_clr_idx ? ST_RUN : ST_INIT;
      w_exc = &r_clr_idx ? 8'h00 : `TRAP_STALL;
    end else if (bus.exception_in != 8'h00) w_exc = bus.exception_in;
    else if (w_mis) w_exc = bus.we ? EXC_ADES : EXC_ADEL;
    else begin
      w_exc = 8'h00;
      w_re = bus.re;
      w_be = !bus.we ? 4'h0 : bus.size == SZ_BYTE ? 4'b0001 << w_off : bus.size == SZ_HALF ? 4'b0011 << w_off : 4'hF;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= INIT_CLEAR ? ST_INIT : ST_RUN;
      r_clr_idx <= '0;
      r_exc <= `TRAP_STALL;
      r_size <= SZ_BYTE;
      r_off <= 2'b00;
      r_sext <= 1'b0;
    end else begin
      r_state <= w_state;
      r_clr_idx <= w_clr_idx;
      r_exc <= w_exc;
      if (w_re) begin
        r_size <= bus.size;
        r_off <= w_off;
        r_sext <= bus.sign_ext;
      end
    end
  dm_byte_ram #(.AW(WA)) u_ram (
    .clk(clk), .rst_n(rst_n), .i_addr(w_waddr), .i_be(w_be), .i_re(w_re), .i_wdata(w_wdata), .o_rdata(w_rdata)
  );
  assign bus.dout = dm_extract(w_rdata, r_off, r_size, r_sext);
  assign bus.exception = r_exc;
  assign bus.busy = r_state == ST_INIT;
endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed vector table, reset/INIT sequences and random ops against a byte-array model.
`ifndef TRAP_STALL
`define TRAP_STALL 8'hFF
`endif
module tb_dm_bytelane;
  localparam int AW = 6;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dm_bytelane_if #(.ADDR_WIDTH(AW)) bus ();
  dm_bytelane #(.ADDR_WIDTH(AW), .INIT_CLEAR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic we, re;
    logic [5:0] addr;
    logic [31:0] din;
    logic [1:0] size;
    logic sx;
    logic [7:0] ei;
    logic [31:0] exp_dout;
    logic [7:0] exp_exc;
  } vec_t;
  vec_t tab [19];
  logic [7:0] mem [64];
  logic [31:0] m_dout;
  logic [7:0] m_exc;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  function automatic logic mis(input logic [1:0] sz, input logic [5:0] a);
    return ALN && ((sz == 2'b01 && a % 2 != 0) || (sz >= 2 && a % 4 != 0));
  endfunction
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 0 ? 1 : sz == 1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] mload(input logic [1:0] sz, input logic [5:0] a, input logic sx);
    int n, base;
    logic [63:0] v;
    n = nbytes(sz);
    base = (int'(a) / n) * n;
    v = 0;
    for (int k = 0; k < n; k++) v = v + (64'(mem[base+k]) << (8*k));
    if (sx && n < 4 && v >= (64'd1 << (8*n-1))) v = v - (64'd1 << (8*n));
    return v[31:0];
  endfunction
  task automatic mstore(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
    int n, base;
    n = nbytes(sz);
    base = (int'(a) / n) * n;
    for (int k = 0; k < n; k++) mem[base+k] = d[8*k +: 8];
  endtask
  task automatic apply(input logic we, input logic re, input logic [5:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sx, input logic [7:0] ei);
    bus.we = we; bus.re = re; bus.addr = a; bus.din = d; bus.size = sz; bus.sign_ext = sx; bus.exception_in = ei;
    @(posedge clk); #1;
    if (ei != 0) m_exc = ei;
    else if (mis(sz, a)) m_exc = we ? 8'h05 : 8'h04;
    else begin
      m_exc = 8'h00;
      if (re) m_dout = mload(sz, a, sx);
      if (we) mstore(sz, a, d);
    end
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, " busy"}, {31'b0, bus.busy}, 32'd1);
    chk({nm, " exc"}, {24'b0, bus.exception}, {24'b0, `TRAP_STALL});
    chk({nm, " dout"}, bus.dout, 32'h0);
  endtask
  task automatic init_seq(input string nm);
    int n = 0;
    bus.we = 1'b1; bus.re = 1'b1; bus.din = '1; bus.size = 2'b10; bus.exception_in = 8'h00;
    rst_n = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!bus.busy) break;
      chk({nm, " stall exc"}, {24'b0, bus.exception}, {24'b0, `TRAP_STALL});
    end
    chk({nm, " init cycles"}, n, 32'd16);
    chk({nm, " exc after init"}, {24'b0, bus.exception}, 32'h0);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    m_dout = 0; m_exc = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    tab[0]  = '{1, 0, 6'h10, 32'h80FF7F01, 2'd2, 0, 8'h00, 32'h0, 8'h00};
    tab[1]  = '{0, 1, 6'h10, 32'h0, 2'd0, 1, 8'h00, 32'h00000001, 8'h00};
    tab[2]  = '{0, 1, 6'h11, 32'h0, 2'd0, 0, 8'h00, 32'h0000007F, 8'h00};
    tab[3]  = '{0, 1, 6'h12, 32'h0, 2'd0, 1, 8'h00, 32'hFFFFFFFF, 8'h00};
    tab[4]  = '{0, 1, 6'h12, 32'h0, 2'd1, 1, 8'h00, 32'hFFFF80FF, 8'h00};
    tab[5]  = '{1, 0, 6'h20, 32'h11223344, 2'd2, 0, 8'h00, 32'hFFFF80FF, 8'h00};
    tab[6]  = '{1, 0, 6'h21, 32'h123456AA, 2'd0, 0, 8'h00, 32'hFFFF80FF, 8'h00};
    tab[7]  = '{0, 1, 6'h20, 32'h0, 2'd2, 0, 8'h00, 32'h1122AA44, 8'h00};
    tab[8]  = '{1, 0, 6'h22, 32'hDEADBEEF, 2'd1, 0, 8'h00, 32'h1122AA44, 8'h00};
    tab[9]  = '{0, 1, 6'h20, 32'h0, 2'd2, 0, 8'h00, 32'hBEEFAA44, 8'h00};
    tab[10] = '{1, 0, 6'h20, 32'h0, 2'd2, 0, 8'h0C, 32'hBEEFAA44, 8'h0C};
    tab[11] = '{0, 1, 6'h20, 32'h0, 2'd3, 0, 8'h00, 32'hBEEFAA44, 8'h00};
    tab[12] = '{1, 0, 6'h02, 32'h12345678, 2'd2, 0, 8'h00, 32'hBEEFAA44, ALN ? 8'h05 : 8'h00};
    tab[13] = '{0, 1, 6'h00, 32'h0, 2'd2, 0, 8'h00, ALN ? 32'h0 : 32'h12345678, 8'h00};
    tab[14] = '{0, 1, 6'h03, 32'h0, 2'd1, 1, 8'h00, ALN ? 32'h0 : 32'h00001234, ALN ? 8'h04 : 8'h00};
    tab[15] = '{1, 1, 6'h04, 32'hCAFEF00D, 2'd2, 0, 8'h00, 32'h0, 8'h00};
    tab[16] = '{0, 1, 6'h04, 32'h0, 2'd2, 0, 8'h00, 32'hCAFEF00D, 8'h00};
    tab[17] = '{1, 1, 6'h05, 32'h0, 2'd1, 0, 8'h00, ALN ? 32'hCAFEF00D : 32'h0000F00D, ALN ? 8'h05 : 8'h00};
    tab[18] = '{0, 1, 6'h04, 32'h0, 2'd2, 0, 8'h00, ALN ? 32'hCAFEF00D : 32'hCAFE0000, 8'h00};
    bus.we = 1'b1; bus.re = 1'b1; bus.din = '1; bus.addr = 6'h0; bus.size = 2'b10; bus.sign_ext = 1'b0; bus.exception_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_rst("mid-init reset");
    @(posedge clk); #1;
    init_seq("init");
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 6'($urandom_range(0, 15) * 4), 32'h0, 2'd2, 0, 8'h00);
      chk("lw after clear", bus.dout, 32'h0);
    end
    for (int i = 0; i < 19; i++) begin
      apply(tab[i].we, tab[i].re, tab[i].addr, tab[i].din, tab[i].size, tab[i].sx, tab[i].ei);
      chk($sformatf("vec%0d dout", i), bus.dout, tab[i].exp_dout);
      chk($sformatf("vec%0d exc", i), {24'b0, bus.exception}, {24'b0, tab[i].exp_exc});
    end
    for (int i = 0; i < 300; i++) begin
      apply(1'($urandom), 1'($urandom), 6'($urandom), $urandom, 2'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0 ? 8'($urandom_range(1, 255)) : 8'h00);
      chk($sformatf("rnd%0d dout", i), bus.dout, m_dout);
      chk($sformatf("rnd%0d exc", i), {24'b0, bus.exception}, {24'b0, m_exc});
    end
    bus.we = 1'b1; bus.re = 1'b0; bus.addr = 6'h08; bus.din = 32'h5A5A5A5A; bus.size = 2'b10; bus.exception_in = 8'h00;
    #3 rst_n = 1'b0;
    #1 chk_rst("mid-store reset");
    @(posedge clk); #1;
    init_seq("reinit");
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 6'($urandom), 32'h0, 2'($urandom), 1'($urandom), 8'h00);
      chk("load after reinit", bus.dout, m_dout);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
